// File: rtl/keypad_pkg.sv
// Shared types, key codes and lookup helpers for the 4x3 keypad scanner.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Row/column to key code. Row 0 is the top row, column 0 the left column.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

  // One-hot digit vector; star, hash and anything above 9 map to zero.
  function automatic logic [9:0] digit_onehot(input logic [3:0] code);
    logic [9:0] v;
    v = 10'd0;
    if (code <= 4'd9) v = 10'd1 << code;
    return v;
  endfunction

  // Active-low one-hot row drive for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'd1 << row);
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational decode of one matrix sample: exactly one low column is a
// valid key, anything else (none or several low) is treated as no key.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [1:0] row,
  input  logic [2:0] cols_n,
  output logic       valid,
  output logic [3:0] code
);

  // Map the single low column on the driven row to its key code.
  always_comb begin
    valid = 1'b0;
    code  = 4'd0;
    case (cols_n)
      3'b110: begin valid = 1'b1; code = key_map(row, 2'd0); end
      3'b101: begin valid = 1'b1; code = key_map(row, 2'd1); end
      3'b011: begin valid = 1'b1; code = key_map(row, 2'd2); end
      default: begin valid = 1'b0; code = 4'd0; end
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: walks the rows, samples the columns once per dwell,
// debounces press and release, and emits one single-cycle pulse per press.
// key_valid is a pure strobe with no back-pressure: the consumer must take
// the key in the single cycle key_valid is high; key_code holds afterwards.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROW_DWELL = 2,
  parameter int DEBOUNCE  = 3
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic [2:0] cols_n,
  output logic [3:0] rows_n,
  output logic [9:0] keypad,
  output logic       key_valid,
  output logic [3:0] key_code,
  output state_t     dbg_state
);

  localparam int DW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t          state;
  logic [DW-1:0]   dwell_cnt;
  logic [1:0]      row;
  logic [CW-1:0]   match_cnt;
  logic [CW-1:0]   rel_cnt;
  logic [3:0]      cap_code;

  logic            sample;
  logic            dec_valid;
  logic [3:0]      dec_code;
  logic [CW-1:0]   match_next;
  logic [CW-1:0]   rel_next;

  // Columns are only looked at on the last clock of each row dwell.
  assign sample     = (dwell_cnt == DWELL_LAST);
  assign match_next = match_cnt + 1'b1;
  assign rel_next   = rel_cnt + 1'b1;
  assign dbg_state  = state;

  keypad_decode u_decode (
    .row    (row),
    .cols_n (cols_n),
    .valid  (dec_valid),
    .code   (dec_code)
  );

  // Scan/debounce/hold FSM with dwell and row counters; all outputs registered.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state     <= ST_SCAN;
      dwell_cnt <= '0;
      row       <= 2'd0;
      rows_n    <= 4'b1110;
      match_cnt <= '0;
      rel_cnt   <= '0;
      cap_code  <= 4'd0;
      keypad    <= 10'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      keypad    <= 10'd0;
      key_valid <= 1'b0;
      dwell_cnt <= sample ? '0 : dwell_cnt + 1'b1;
      if (sample) begin
        case (state)
          ST_SCAN: begin
            if (dec_valid) begin
              // Freeze on this row and start counting matching samples.
              cap_code  <= dec_code;
              match_cnt <= CNT_ONE;
              rel_cnt   <= '0;
              if (CNT_DONE == CNT_ONE) begin
                state     <= ST_HOLD;
                key_valid <= 1'b1;
                key_code  <= dec_code;
                keypad    <= digit_onehot(dec_code);
              end else begin
                state <= ST_DEBOUNCE;
              end
            end else begin
              row    <= row + 2'd1;
              rows_n <= row_drive(row + 2'd1);
            end
          end
          ST_DEBOUNCE: begin
            if (dec_valid && (dec_code == cap_code)) begin
              match_cnt <= match_next;
              if (match_next == CNT_DONE) begin
                state     <= ST_HOLD;
                rel_cnt   <= '0;
                key_valid <= 1'b1;
                key_code  <= cap_code;
                keypad    <= digit_onehot(cap_code);
              end
            end else begin
              // Bounce or a different key: drop it silently and move on.
              state     <= ST_SCAN;
              match_cnt <= '0;
              row       <= row + 2'd1;
              rows_n    <= row_drive(row + 2'd1);
            end
          end
          ST_HOLD: begin
            // Only a run of all-high samples counts as release; other keys are ignored.
            if (cols_n == 3'b111) begin
              if (rel_next == CNT_DONE) begin
                state     <= ST_SCAN;
                rel_cnt   <= '0;
                match_cnt <= '0;
                row       <= row + 2'd1;
                rows_n    <= row_drive(row + 2'd1);
              end else begin
                rel_cnt <= rel_next;
              end
            end else begin
              rel_cnt <= '0;
            end
          end
          default: begin
            state <= ST_SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives and reads a 4x3 telephone-style key matrix and produces the 10-bit one-hot `keypad` digit vector consumed by the microwave oven controller. It is the transmitting end of the keypad interface. Each debounced press yields exactly one single-cycle one-hot pulse, so a held key never enters the same digit twice. It sits between the board's matrix pins and the oven's `keypad` input, on the oven's clock.

## Interface
- `ROW_DWELL`, 2: clocks each row is driven before advancing; the column is sampled on the last clock of the dwell. Minimum 1.
- `DEBOUNCE`, 3: consecutive identical samples required to accept a press, and to accept a release. Minimum 1.
- `clock` in 1: system clock. All state changes occur on the rising edge.
- `clearn` in 1: reset, asynchronous and active-low.
- `cols_n` in 3: matrix columns, active-low, pulled up externally. Bit 0 is the left column.
- `rows_n` out 4: matrix row drive, one-hot active-low. Bit 0 is the top row.
- `keypad` out 10: one-hot digit pulse. Bit n means digit n. High for exactly 1 clock per accepted digit press.
- `key_valid` out 1: 1-clock strobe for every accepted press, including `*` and `#`.
- `key_code` out 4: code of the last accepted key. Values are 0-9, 10 for `*`, and 11 for `#`. It holds its value between presses.

## Operation
- Key map:
  - row0: 1 2 3
  - row1: 4 5 6
  - row2: 7 8 9
  - row3: * 0 #
- A sample is "valid" only if exactly one `cols_n` bit is low. Zero or multiple low bits count as "no key".
- States: SCAN, DEBOUNCE, HOLD.
- **SCAN**
  - The row counter advances 0→1→2→3→0 every `ROW_DWELL` clocks, and `rows_n` follows it.
  - On a valid sample, capture the code, set the match count to 1, and freeze the row.
  - If `DEBOUNCE`=1, go to HOLD and pulse. Otherwise go to DEBOUNCE.
- **DEBOUNCE**
  - The row stays frozen. Sample once per `ROW_DWELL` period.
  - Same code: increment the count. When it reaches `DEBOUNCE`, pulse and go to HOLD.
  - Different code or no key: discard with no pulse, return to SCAN, and advance to the next row.
- **HOLD**
  - The row stays frozen. Each sample of all columns high increments the release count; any low column clears it.
  - At `DEBOUNCE` consecutive releases, go to SCAN on the next row.
  - Any other key pressed during HOLD is ignored.
- **Pulse**
  - `key_valid`=1 and `key_code` is updated.
  - `keypad`=1<<code only for codes 0-9. For `*` and `#`, `keypad` stays 0.
- **Reset values**
  - State SCAN, row 0, counts 0.
  - `rows_n`=4'b1110, `keypad`=0, `key_valid`=0, `key_code`=0.
- **Reset mid-operation:** asserting `clearn` aborts any debounce or hold at once, with no pulse. After release, scanning restarts at row 0.

## Timing
- All outputs are registered. There is no combinational path from `cols_n` to the outputs.
- Sample instants are the rising edges ending each dwell: edge `ROW_DWELL`, then 2·`ROW_DWELL`, and so on after `clearn` deasserts.
- The pulse is visible in the cycle after the edge that takes the `DEBOUNCE`-th matching sample.
- Press latency, from the first valid sample to the pulse: (`DEBOUNCE`−1)·`ROW_DWELL`+1 clocks. With defaults this is 5.
- The minimum press-to-press spacing accepted is 2·`DEBOUNCE`·`ROW_DWELL` clocks plus the scan time back to the row.
- The row counter wraps from 3 to 0 with no idle cycle.
- `keypad` and `key_valid` are never high for two consecutive clocks.

## Structure
- Package `keypad_pkg` contains:
  - state enum {SCAN, DEBOUNCE, HOLD}
  - constants KEY_STAR=10 and KEY_HASH=11
  - the row/column-to-code map
  - a function returning the 10-bit one-hot value for codes 0-9, and 0 otherwise
- Sub-module `keypad_decode` is purely combinational. It takes row index and `cols_n` and returns a valid flag and the code.
- The top level holds the FSM, the dwell counter, the row counter and the match/release counters. Counter widths are sized by $clog2 of the parameters.

## Test plan
All scenarios use default parameters.
- Reset then idle, `cols_n`=3'b111: `rows_n` cycles 1110→1101→1011→0111 every 2 clocks, and no `key_valid` ever.
- Hold key "6" (low `cols_n`[2] whenever row1 is driven) for 100 clocks: exactly one pulse with `keypad`=10'b0001000000 and `key_code`=6. `rows_n` stays 4'b1101 until 6 consecutive released clocks.
- Enter 2, 0, 6 with releases between them: three pulses with `keypad` 0x004, 0x001, 0x040 in order, matching the oven's digit-entry sequence.
- Press `#` for 20 clocks: `key_valid` pulses with `key_code`=11 and `keypad` stays 0.
- Bounce "5": low for 1 sample, high for 1, then low steady. There is no pulse on the first contact, and exactly one pulse 5 clocks after the steady low is first sampled.
- Two columns of row0 low at once produce no pulse. Asserting `clearn` during DEBOUNCE of "9" gives no pulse, and all outputs equal their reset values while `clearn`=0.
